counter_cmd_sequencer: RTL and testbench

COUNTER_CMD_SEQUENCER -- requirements
Module: counter_cmd_sequencer

---
 rtl/counter_cmd_sequencer.sv | 149 ++++++++++++++
 tb/tb_counter_cmd_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_cmd_sequencer.sv
// rtl/counter_cmd_sequencer.sv - command FIFO + IDLE/LOAD/RUN sequencer driving an up/down counter, with counter reference model.
// Optional SEQ_CHECK_EN adds mismatch / mism_cnt comparison of data_out against exp_value.
module counter_cmd_sequencer #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [7:0] cmd_arg,
   output logic       load,
   output logic       updown,
   output logic [7:0] data_in,
   input  logic [7:0] data_out,
   output logic       busy,
   output logic [7:0] exp_value
`ifdef SEQ_CHECK_EN
   ,
   output logic       mismatch,
   output logic [7:0] mism_cnt
`endif
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PW:0] CNT_ONE  = 1;
   localparam logic [PW:0] CNT_FULL = FIFO_DEPTH;
   localparam logic [PW-1:0] PTR_ONE = 1;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_UP   = 2'b01;
   localparam logic [1:0] OP_DOWN = 2'b10;

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [9:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic [PW:0]   count_nxt;
   logic [7:0]    run_cnt;
   logic          push;
   logic          pop;
   logic          empty;
   logic [1:0]    head_op;
   logic [7:0]    head_arg;

   assign push     = cmd_valid && cmd_ready;
   assign empty    = (count == '0);
   assign head_op  = mem[rd_ptr][9:8];
   assign head_arg = mem[rd_ptr][7:0];
   assign load     = (state == LOAD);
   assign busy     = (state != IDLE) || !empty;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {cmd_op, cmd_arg};
      end
   end

   // A command finishes in IDLE/LOAD every cycle, in RUN on its last counted cycle;
   // the next head is popped at that edge so back-to-back commands have no bubble.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      if ((state != RUN) || (run_cnt == 8'd0)) begin
         if (!empty) begin
            pop = 1'b1;
            case (head_op)
               OP_LOAD:        state_nxt = LOAD;
               OP_UP, OP_DOWN: state_nxt = RUN;
               default:        state_nxt = IDLE;
            endcase
         end else begin
            state_nxt = IDLE;
         end
      end
   end

   always_comb begin
      count_nxt = count;
      if (push && !pop) begin
         count_nxt = count + CNT_ONE;
      end else if (!push && pop) begin
         count_nxt = count - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         cmd_ready <= 1'b1;
         updown    <= 1'b1;
         data_in   <= 8'd0;
         run_cnt   <= 8'd0;
         exp_value <= 8'd0;
      end else begin
         state     <= state_nxt;
         count     <= count_nxt;
         cmd_ready <= (count_nxt != CNT_FULL);
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         exp_value <= load ? data_in : (updown ? exp_value + 8'd1 : exp_value - 8'd1);
         if (pop && head_op == OP_LOAD) begin
            data_in <= head_arg;
         end
         // run_cnt holds remaining cycles minus one, so arg=0 wraps to 256 cycles.
         if (pop && (head_op == OP_UP || head_op == OP_DOWN)) begin
            updown  <= (head_op == OP_UP);
            run_cnt <= head_arg - 8'd1;
         end else if (state == RUN) begin
            run_cnt <= run_cnt - 8'd1;
         end
      end
   end

`ifdef SEQ_CHECK_EN
   logic armed;

   assign mismatch = armed && (data_out != exp_value);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         armed    <= 1'b0;
         mism_cnt <= 8'd0;
      end else begin
         if (state == LOAD) begin
            armed <= 1'b1;
         end
         if (mismatch && mism_cnt != 8'hFF) begin
            mism_cnt <= mism_cnt + 8'd1;
         end
      end
   end
`else
   logic unused_data_out;
   assign unused_data_out = ^data_out;
`endif

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// tb/tb_counter_cmd_sequencer.sv - scoreboard bench: per-cycle expected outputs expanded from accepted commands.
// Builds with or without SEQ_CHECK_EN.
module tb_counter_cmd_sequencer;
   localparam int DEPTH = 4;
   localparam logic [1:0] OP_LOAD = 2'b00, OP_UP = 2'b01, OP_DOWN = 2'b10, OP_NOP = 2'b11;
   localparam int K_LOAD = 0, K_RUN = 1, K_NOP = 2;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_op = 2'b11;
   logic [7:0] cmd_arg = 8'd0;
   logic       cmd_ready, load, updown, busy;
   logic [7:0] data_in, data_out, exp_value;
   logic [7:0] ctr;
   logic [7:0] err_off = 8'd0;
`ifdef SEQ_CHECK_EN
   logic       mismatch;
   logic [7:0] mism_cnt;
`endif

   typedef struct {
      int       tag;
      int       kind;
      logic     ud;
      logic [7:0] di;
      bit       first;
   } rec_t;

   rec_t q[$];
   int   edge_no = 0;
   bit   rst_edge = 1'b0;
   bit   saw_full = 1'b0;
   int   tests = 0;
   int   fails = 0;

   counter_cmd_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_arg(cmd_arg), .load(load), .updown(updown),
      .data_in(data_in), .data_out(data_out), .busy(busy), .exp_value(exp_value)
`ifdef SEQ_CHECK_EN
      , .mismatch(mismatch), .mism_cnt(mism_cnt)
`endif
   );

   always #5 clk = ~clk;

   // The counter being sequenced; err_off lets the bench corrupt what it reports.
   always @(posedge clk) begin
      if (!resetn) ctr <= 8'd0;
      else ctr <= load ? data_in : (updown ? ctr + 8'd1 : ctr - 8'd1);
   end
   assign data_out = ctr + err_off;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_no);
      end
   endtask

   // Accepted commands expand into one expected record per output cycle.
   initial forever begin
      @(posedge clk);
      edge_no++;
      rst_edge = !resetn;
      if (!resetn) begin
         q.delete();
      end else if (cmd_valid && cmd_ready) begin
         case (cmd_op)
            OP_LOAD: q.push_back('{tag: edge_no, kind: K_LOAD, ud: 1'b0, di: cmd_arg, first: 1'b1});
            OP_NOP:  q.push_back('{tag: edge_no, kind: K_NOP, ud: 1'b0, di: 8'd0, first: 1'b1});
            default: begin
               for (int i = 0; i < ((cmd_arg == 8'd0) ? 256 : int'(cmd_arg)); i++)
                  q.push_back('{tag: edge_no, kind: K_RUN, ud: (cmd_op == OP_UP), di: 8'd0, first: (i == 0)});
            end
         endcase
      end
      if (resetn && cmd_valid && !cmd_ready) saw_full = 1'b1;
   end

   initial begin : monitor
      logic [7:0] refv, hold_di, p_di;
      logic       hold_ud, p_ud, p_load, e_load;
      bit         active;
      int         occ;
      rec_t       r;
      refv = 0; hold_di = 0; p_di = 0; hold_ud = 1; p_ud = 1; p_load = 0; e_load = 0; active = 0;
      forever begin
         @(negedge clk);
         if (edge_no > 0) begin
            if (rst_edge) begin
               refv = 8'd0; hold_ud = 1'b1; hold_di = 8'd0; e_load = 1'b0; active = 1'b0;
            end else begin
               refv = p_load ? p_di : (p_ud ? refv + 8'd1 : refv - 8'd1);
               e_load = 1'b0;
               active = 1'b0;
               if (q.size() > 0 && q[0].tag < edge_no) begin
                  r = q.pop_front();
                  active = (r.kind != K_NOP);
                  if (r.kind == K_LOAD) begin
                     e_load = 1'b1;
                     hold_di = r.di;
                  end else if (r.kind == K_RUN) begin
                     hold_ud = r.ud;
                  end
               end
            end
            occ = 0;
            foreach (q[i]) if (q[i].first) occ++;
            chk("load", load, e_load);
            chk("updown", updown, hold_ud);
            chk("data_in", data_in, hold_di);
            chk("exp_value", exp_value, refv);
            chk("cmd_ready", cmd_ready, (occ < DEPTH) ? 1 : 0);
            chk("busy", busy, (occ > 0 || active) ? 1 : 0);
            p_load = e_load; p_ud = hold_ud; p_di = hold_di;
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [1:0] op, input logic [7:0] arg);
      int t = 0;
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_arg = arg;
      while (!cmd_ready && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (!cmd_ready) chk("send_timeout", cmd_ready, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (busy && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (busy) chk("idle_timeout", busy, 0);
   endtask

   initial begin
      logic [1:0] op;
      logic [7:0] arg;
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_load", load, 0);
      chk("rst_updown", updown, 1);
      chk("rst_data_in", data_in, 0);
      chk("rst_exp_value", exp_value, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      resetn = 1'b1;
      @(negedge clk);

`ifdef SEQ_CHECK_EN
      chk("mism_cnt_rst", mism_cnt, 0);
      send(OP_LOAD, 8'h40);
      @(negedge clk);
      @(negedge clk);
      err_off = 8'd1;
      #1 chk("mismatch_on1", mismatch, 1);
      @(negedge clk);
      chk("mismatch_on2", mismatch, 1);
      @(negedge clk);
      err_off = 8'd0;
      #1 chk("mismatch_off", mismatch, 0);
      chk("mism_cnt_two", mism_cnt, 2);
      wait_idle();
`endif

      send(OP_LOAD, 8'h10); send(OP_UP, 8'd3); wait_idle();
      send(OP_LOAD, 8'hFE); send(OP_UP, 8'd3);
      send(OP_LOAD, 8'h01); send(OP_DOWN, 8'd2); wait_idle();

      saw_full = 1'b0;
      send(OP_UP, 8'd10);
      send(OP_LOAD, 8'h33); send(OP_DOWN, 8'd2); send(OP_NOP, 8'd0);
      send(OP_UP, 8'd2); send(OP_LOAD, 8'h77);
      chk("burst_full_seen", saw_full, 1);
      wait_idle();

      send(OP_LOAD, 8'h5A); send(OP_UP, 8'd0); wait_idle();

      send(OP_LOAD, 8'h20); send(OP_DOWN, 8'd50); send(OP_UP, 8'd5); send(OP_LOAD, 8'h07);
      repeat (10) @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_load", load, 0);
      chk("midrst_exp_value", exp_value, 0);
      chk("midrst_cmd_ready", cmd_ready, 1);
      resetn = 1'b1;
      repeat (3) @(negedge clk);
      chk("midrst_stays_idle", busy, 0);

      for (int n = 0; n < 60; n++) begin
         op = 2'($urandom_range(0, 3));
         if (op == OP_LOAD || op == OP_NOP) arg = 8'($urandom_range(0, 255));
         else arg = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
         send(op, arg);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle();
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
